// File: rtl/gray_to_bin_tracker.sv
// gray_to_bin_tracker: decodes sampled Gray codes and tracks signed position from single-bit steps
module gray_to_bin_tracker #(
  parameter int WID  = 4,
  parameter int PWID = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [WID-1:0]  gray_in,
  input  logic            sample_en,
  input  logic            err_clr,
  output logic [WID-1:0]  bin_out,
  output logic            bin_valid,
  output logic            step_up,
  output logic            step_dn,
  output logic [PWID-1:0] pos,
  output logic            err_multi
);
  typedef enum logic {EMPTY, TRACK} state_t;
  state_t state_q, state_d;
  logic [WID-1:0] dec, diff, bin_q, bin_d, prev_gray_q, prev_gray_d;
  logic [PWID-1:0] pos_q, pos_d;
  logic valid_q, valid_d, up_q, up_d, dn_q, dn_d, err_q, err_d;
  logic track, one_hot, multi;
  always_comb begin
    for (int i = 0; i < WID; i++) dec[i] = ^(gray_in >> i);
    diff        = gray_in ^ prev_gray_q;
    one_hot     = (diff != '0) && ((diff & (diff - WID'(1))) == '0);
    track       = sample_en && (state_q == TRACK);
    multi       = track && (diff != '0) && !one_hot;
    up_d        = track && one_hot && (dec == bin_q + WID'(1));
    dn_d        = track && one_hot && (dec != bin_q + WID'(1));
    pos_d       = pos_q + PWID'(up_d) - PWID'(dn_d);
    err_d       = multi | (err_q & ~err_clr);
    valid_d     = sample_en;
    bin_d       = sample_en ? dec : bin_q;
    prev_gray_d = sample_en ? gray_in : prev_gray_q;
    state_d     = sample_en ? TRACK : state_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      bin_q       <= '0;
      prev_gray_q <= '0;
      pos_q       <= '0;
      valid_q     <= 1'b0;
      up_q        <= 1'b0;
      dn_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      prev_gray_q <= prev_gray_d;
      pos_q       <= pos_d;
      valid_q     <= valid_d;
      up_q        <= up_d;
      dn_q        <= dn_d;
      err_q       <= err_d;
    end
  end
  assign bin_out   = bin_q;
  assign bin_valid = valid_q;
  assign step_up   = up_q;
  assign step_dn   = dn_q;
  assign pos       = pos_q;
  assign err_multi = err_q;
endmodule

// File: tb/tb_gray_to_bin_tracker.sv
// tb_gray_to_bin_tracker: randomized and directed checks against a behavioural tracker model
module tb_gray_to_bin_tracker;
  logic clk = 1'b0;
  logic reset, sample_en, err_clr;
  logic [3:0] gray_in, bin_out;
  logic bin_valid, step_up, step_dn, err_multi;
  logic [15:0] pos;
  int tests = 0, fails = 0;
  bit m_track, m_err, e_valid, e_up, e_dn;
  int m_bin, m_prev, m_pos;
  gray_to_bin_tracker #(.WID(4), .PWID(16)) dut (
    .clk(clk), .reset(reset), .gray_in(gray_in), .sample_en(sample_en), .err_clr(err_clr),
    .bin_out(bin_out), .bin_valid(bin_valid), .step_up(step_up), .step_dn(step_dn),
    .pos(pos), .err_multi(err_multi)
  );
  always #5 clk = ~clk;
  function automatic int g2b(int g);
    for (int v = 0; v < 16; v++) if ((v ^ (v >> 1)) == g) return v;
    return -1;
  endfunction
  function automatic int popc(int x);
    int c = 0;
    for (int i = 0; i < 4; i++) c += (x >> i) & 1;
    return c;
  endfunction
  function automatic void model_reset();
    m_track = 0; m_err = 0; e_valid = 0; e_up = 0; e_dn = 0;
    m_bin = 0; m_prev = 0; m_pos = 0;
  endfunction
  task automatic step(input bit se, input int g, input bit clr);
    int b, d;
    bit multi;
    sample_en = se; gray_in = g[3:0]; err_clr = clr;
    @(posedge clk);
    e_valid = se; e_up = 0; e_dn = 0; multi = 0;
    if (se) begin
      b = g2b(g);
      if (m_track) begin
        d = popc(g ^ m_prev);
        if (d == 1) begin
          if (b == (m_bin + 1) % 16) begin e_up = 1; m_pos++; end
          else begin e_dn = 1; m_pos--; end
        end else if (d >= 2) multi = 1;
      end
      m_bin = b; m_prev = g; m_track = 1;
    end
    if (multi) m_err = 1;
    else if (clr) m_err = 0;
    #1;
  endtask
  task automatic apply_reset();
    reset = 1; sample_en = 0; err_clr = 0; gray_in = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 0;
  endtask
  task automatic test_reset();
    apply_reset();
    step(1, 3, 0);
    step(1, 1, 0);
    reset = 1; sample_en = 1; gray_in = 4'hA;
    #1;
    model_reset();
    if ({bin_out, bin_valid, step_up, step_dn, err_multi, pos} !== 24'd0) begin
      fails++; $display("FAIL reset_async: got %h want 0", {bin_out, bin_valid, step_up, step_dn, err_multi, pos});
    end
    tests++;
    repeat (3) @(posedge clk);
    #1;
    if ({bin_out, bin_valid, step_up, step_dn, err_multi, pos} !== 24'd0) begin
      fails++; $display("FAIL reset_hold_sample_en: got %h want 0", {bin_out, bin_valid, step_up, step_dn, err_multi, pos});
    end
    tests++;
    @(negedge clk) reset = 0;
  endtask
  task automatic test_sweep();
    apply_reset();
    for (int v = 0; v < 16; v++) begin
      step(1, v ^ (v >> 1), 0);
      if ({bin_out, bin_valid, step_up, step_dn, err_multi, pos} !== {m_bin[3:0], e_valid, e_up, e_dn, m_err, m_pos[15:0]}
          || bin_out !== v[3:0] || step_up !== (v != 0)) begin
        fails++; $display("FAIL sweep[%0d]: got %h want %h", v, {bin_out, bin_valid, step_up, step_dn, err_multi, pos},
                          {m_bin[3:0], e_valid, e_up, e_dn, m_err, m_pos[15:0]});
      end
      tests++;
    end
    if (pos !== 16'd15 || err_multi !== 1'b0) begin
      fails++; $display("FAIL sweep_final: pos=%0d err=%b want 15/0", pos, err_multi);
    end
    tests++;
  endtask
  task automatic test_wrap();
    step(1, 0, 0);
    if (step_up !== 1'b1 || step_dn !== 1'b0 || bin_out !== 4'd0 || pos !== m_pos[15:0]) begin
      fails++; $display("FAIL wrap_up: up=%b dn=%b bin=%0d pos=%0d want 1/0/0/%0d", step_up, step_dn, bin_out, pos, m_pos);
    end
    tests++;
    step(1, 8, 0);
    if (step_dn !== 1'b1 || step_up !== 1'b0 || bin_out !== 4'd15 || pos !== m_pos[15:0]) begin
      fails++; $display("FAIL wrap_dn: up=%b dn=%b bin=%0d pos=%0d want 0/1/15/%0d", step_up, step_dn, bin_out, pos, m_pos);
    end
    tests++;
  endtask
  task automatic test_illegal();
    logic [15:0] p0;
    step(1, 7, 0);
    step(0, 0, 1);
    if (err_multi !== 1'b0) begin
      fails++; $display("FAIL illegal_clear: err=%b want 0", err_multi);
    end
    tests++;
    p0 = pos;
    step(1, 4, 0);
    if (err_multi !== 1'b1 || step_up !== 1'b0 || step_dn !== 1'b0 || pos !== p0 || bin_out !== 4'd7 || bin_valid !== 1'b1) begin
      fails++; $display("FAIL illegal_jump: err=%b up=%b dn=%b pos=%0d bin=%0d want 1/0/0/%0d/7", err_multi, step_up, step_dn, pos, bin_out, p0);
    end
    tests++;
  endtask
  task automatic test_priority();
    step(0, 0, 1);
    step(1, 7, 1);
    if (err_multi !== 1'b1) begin
      fails++; $display("FAIL prio_set_wins: err=%b want 1", err_multi);
    end
    tests++;
    step(0, 0, 1);
    if (err_multi !== 1'b0) begin
      fails++; $display("FAIL prio_clear: err=%b want 0", err_multi);
    end
    tests++;
  endtask
  task automatic test_hold();
    logic [3:0] b0;
    logic [15:0] p0;
    logic e0;
    step(1, 5, 0);
    b0 = bin_out; p0 = pos; e0 = err_multi;
    for (int k = 0; k < 5; k++) begin
      step(0, k[0] ? 15 : int'($urandom_range(0, 15)), 0);
      if (bin_out !== b0 || pos !== p0 || err_multi !== e0 || bin_valid || step_up || step_dn) begin
        fails++; $display("FAIL hold[%0d]: bin=%0d pos=%0d err=%b v/u/d=%b%b%b want %0d/%0d/%b/000",
                          k, bin_out, pos, err_multi, bin_valid, step_up, step_dn, b0, p0, e0);
      end
      tests++;
    end
  endtask
  task automatic test_reset_mid();
    apply_reset();
    for (int v = 0; v < 4; v++) step(1, v ^ (v >> 1), 0);
    if (pos !== 16'd3) begin
      fails++; $display("FAIL mid_pre: pos=%0d want 3", pos);
    end
    tests++;
    reset = 1;
    #1;
    model_reset();
    if ({bin_out, bin_valid, step_up, step_dn, err_multi, pos} !== 24'd0) begin
      fails++; $display("FAIL mid_reset: got %h want 0", {bin_out, bin_valid, step_up, step_dn, err_multi, pos});
    end
    tests++;
    @(negedge clk) reset = 0;
    step(1, 5, 0);
    if (bin_out !== 4'd6 || bin_valid !== 1'b1 || step_up || step_dn || err_multi || pos !== 16'd0) begin
      fails++; $display("FAIL mid_first: bin=%0d v=%b u=%b d=%b err=%b pos=%0d want 6/1/0/0/0/0",
                        bin_out, bin_valid, step_up, step_dn, err_multi, pos);
    end
    tests++;
  endtask
  task automatic test_random();
    int g;
    apply_reset();
    for (int n = 0; n < 300; n++) begin
      g = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : (m_prev ^ (1 << $urandom_range(0, 3)));
      step($urandom_range(0, 4) != 0, g, $urandom_range(0, 9) == 0);
      if ({bin_out, bin_valid, step_up, step_dn, err_multi, pos} !== {m_bin[3:0], e_valid, e_up, e_dn, m_err, m_pos[15:0]}
          || (step_up && step_dn)) begin
        fails++; $display("FAIL random[%0d]: got %h want %h", n, {bin_out, bin_valid, step_up, step_dn, err_multi, pos},
                          {m_bin[3:0], e_valid, e_up, e_dn, m_err, m_pos[15:0]});
      end
      tests++;
    end
  endtask
  initial begin
    reset = 1; sample_en = 0; err_clr = 0; gray_in = 0;
    test_reset();
    test_sweep();
    test_wrap();
    test_illegal();
    test_priority();
    test_hold();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
